// File: rtl/compact_instruction_packer_pkg.sv
// Shared RV32I / RVC encoding constants and packer state type, also used by the expander.
package compact_instruction_packer_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  localparam logic [2:0] CF3_ADDI   = 3'b000;
  localparam logic [2:0] CF3_LI     = 3'b010;
  localparam logic [2:0] CF3_ARITH  = 3'b100;
  localparam logic [2:0] CF3_MV_ADD = 3'b100;
  localparam logic [2:0] CF3_LW     = 3'b010;
  localparam logic [2:0] CF3_SW     = 3'b110;
  localparam logic [2:0] CF3_LWSP   = 3'b010;
  localparam logic [2:0] CF3_SWSP   = 3'b110;
  localparam logic [2:0] C_ARITH_HI = 3'b011;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_PAD = 1'b1
  } pack_state_e;

  // Compressed 3-bit register fields only reach x8..x15.
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/compact_instruction_packer_rvc_compress_encoder.sv
// Combinational RV32I -> RVC re-encoder; flags instructions with an exact 16-bit form.
// Load/store compression is built only when COMPACT_LOADSTORE_EN is defined.
module rvc_compress_encoder
  import compact_instruction_packer_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_compressible,
  output logic [15:0] code
);

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i;
  logic        imm_i_small;
  logic [1:0]  arith_f2;

  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];
  assign imm_i = instr[31:20];
  // Fits the 6-bit signed range -32..31.
  assign imm_i_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

`ifdef COMPACT_LOADSTORE_EN
  logic [11:0] imm_s;
  assign imm_s = {instr[31:25], instr[11:7]};
`endif

  always_comb begin
    case (f3)
      F3_XOR:  arith_f2 = 2'b01;
      F3_OR:   arith_f2 = 2'b10;
      F3_AND:  arith_f2 = 2'b11;
      default: arith_f2 = 2'b00;
    endcase
  end

  always_comb begin
    is_compressible = 1'b0;
    code            = C_NOP;
    if (opc == OPC_OP && f3 == F3_ADD_SUB && f7 == F7_BASE &&
        rd != 5'd0 && rs2 != 5'd0 && rs1 == rd) begin
      is_compressible = 1'b1;
      code = {CF3_MV_ADD, 1'b1, rd, rs2, C_Q2};
    end else if (opc == OPC_OP && f3 == F3_ADD_SUB && f7 == F7_BASE &&
                 rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
      is_compressible = 1'b1;
      code = {CF3_MV_ADD, 1'b0, rd, rs2, C_Q2};
    end else if (opc == OPC_OP && rs1 == rd && is_creg(rd) && is_creg(rs2) &&
                 ((f7 == F7_SUB && f3 == F3_ADD_SUB) ||
                  (f7 == F7_BASE && (f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND)))) begin
      is_compressible = 1'b1;
      code = {CF3_ARITH, C_ARITH_HI, rd[2:0], arith_f2, rs2[2:0], C_Q1};
    end else if (opc == OPC_OP_IMM && f3 == F3_ADDI && rd != 5'd0 && rs1 == rd &&
                 imm_i != 12'd0 && imm_i_small) begin
      is_compressible = 1'b1;
      code = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], C_Q1};
    end else if (opc == OPC_OP_IMM && f3 == F3_ADDI && rd != 5'd0 && rs1 == 5'd0 &&
                 imm_i_small) begin
      is_compressible = 1'b1;
      code = {CF3_LI, imm_i[5], rd, imm_i[4:0], C_Q1};
    end else if (opc == OPC_OP_IMM && f3 == F3_ADDI && rd == 5'd0 && rs1 == 5'd0 &&
                 imm_i == 12'd0) begin
      is_compressible = 1'b1;
      code = C_NOP;
    end
`ifdef COMPACT_LOADSTORE_EN
    else if (opc == OPC_LOAD && f3 == F3_LW && is_creg(rd) && is_creg(rs1) &&
             imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'd0) begin
      is_compressible = 1'b1;
      code = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], C_Q0};
    end else if (opc == OPC_STORE && f3 == F3_SW && is_creg(rs2) && is_creg(rs1) &&
                 imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'd0) begin
      is_compressible = 1'b1;
      code = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], C_Q0};
    end else if (opc == OPC_LOAD && f3 == F3_LW && rs1 == 5'd2 && rd != 5'd0 &&
                 imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'd0) begin
      is_compressible = 1'b1;
      code = {CF3_LWSP, imm_i[5], rd, imm_i[4:2], imm_i[7:6], C_Q2};
    end else if (opc == OPC_STORE && f3 == F3_SW && rs1 == 5'd2 &&
                 imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'd0) begin
      is_compressible = 1'b1;
      code = {CF3_SWSP, imm_s[5:2], imm_s[7:6], rs2, C_Q2};
    end
`endif
  end

endmodule

// File: rtl/compact_instruction_packer.sv
// Packs RVC-compressed / pass-through instructions little-endian into 32-bit words.
// Optional load/store compression: define COMPACT_LOADSTORE_EN.
//
// state | meaning
// RUN   | accepting instructions, packing halfwords
// PAD   | final word sent, leftover halfword waits to go out padded with C.NOP
module compact_instruction_packer
  import compact_instruction_packer_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instruction,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_word,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] compressed_count
);

  pack_state_e            state_q, state_d;
  logic [15:0]            hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [31:0]            out_word_q, out_word_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic        is_c;
  logic [15:0] c_code;
  logic        slot_free;
  logic        accept;

  rvc_compress_encoder u_enc (
    .instr           (in_instruction),
    .is_compressible (is_c),
    .code            (c_code)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && slot_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (state_q == ST_PAD) begin
      if (slot_free) begin
        out_word_d  = {C_NOP, hold_q};
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        hold_full_d = 1'b0;
        state_d     = ST_RUN;
      end
    end else if (accept) begin
      if (is_c) begin
        if (count_q != {COUNT_WIDTH{1'b1}}) count_d = count_q + COUNT_WIDTH'(1);
        if (hold_full_q) begin
          out_word_d  = {c_code, hold_q};
          out_valid_d = 1'b1;
          out_last_d  = in_last;
          hold_full_d = 1'b0;
        end else if (in_last) begin
          out_word_d  = {C_NOP, c_code};
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end else begin
          hold_d      = c_code;
          hold_full_d = 1'b1;
        end
      end else begin
        if (hold_full_q) begin
          // The instruction straddles: low half completes this word, high half is held.
          out_word_d  = {in_instruction[15:0], hold_q};
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          hold_d      = in_instruction[31:16];
          if (in_last) state_d = ST_PAD;
        end else begin
          out_word_d  = in_instruction;
          out_valid_d = 1'b1;
          out_last_d  = in_last;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      hold_q      <= 16'd0;
      hold_full_q <= 1'b0;
      out_word_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_word         = out_word_q;
  assign out_last         = out_last_q;
  assign compressed_count = count_q;

endmodule

// File: tb/tb_compact_instruction_packer.sv
// Directed self-checking bench for compact_instruction_packer (COUNT_WIDTH=4).
module tb_compact_instruction_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_last;
  logic [3:0]  compressed_count;

  int tests = 0;
  int fails = 0;

`ifdef COMPACT_LOADSTORE_EN
  localparam logic [31:0] LW_WORD = 32'h0001_4404;
  localparam int          LW_CNT  = 13;
`else
  localparam logic [31:0] LW_WORD = 32'h0084_2483;
  localparam int          LW_CNT  = 12;
`endif

  compact_instruction_packer #(.COUNT_WIDTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instruction   (in_instruction),
    .in_last          (in_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_word         (out_word),
    .out_last         (out_last),
    .compressed_count (compressed_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_instruction = ins;
    in_last = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for instr %h", ins);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_word(input string tag, input logic [31:0] w, input logic l);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_word"}, out_word, w);
    chk({tag, "_last"}, 32'(out_last), 32'(l));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_instruction = 32'd0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(compressed_count), 32'd0);

    // Two C.ADD halves form one word
    send(32'h0094_0433, 1'b0);
    chk("add1_held", 32'(out_valid), 32'd0);
    send(32'h0094_0433, 1'b0);
    wait_word("add_pair", 32'h9426_9426, 1'b0);
    chk("add_pair_count", 32'(compressed_count), 32'd2);

    // C.SUB + C.LI closing the stream
    send(32'h4094_0433, 1'b0);
    send(32'h0050_0513, 1'b1);
    wait_word("sub_li", 32'h4515_8C05, 1'b1);
    chk("sub_li_count", 32'(compressed_count), 32'd4);

    // Straddling last instruction forces a PAD word
    send(32'h0094_0433, 1'b0);
    send(32'h0640_0513, 1'b1);
    chk("pad_in_ready", 32'(in_ready), 32'd0);
    wait_word("straddle", 32'h0513_9426, 1'b0);
    wait_word("pad", 32'h0001_0640, 1'b1);
    chk("pad_back_run", 32'(in_ready), 32'd1);
    chk("pad_count", 32'(compressed_count), 32'd5);

    // Backpressure: word must stay put
    out_ready = 1'b0;
    send(32'h0094_0433, 1'b0);
    send(32'h1234_52B7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_word", out_word, 32'h52B7_9426);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_one_xfer", 32'(out_valid), 32'd0);
    send(32'h0000_0013, 1'b1);
    wait_word("nop_flush", 32'h0001_1234, 1'b1);
    chk("stall_count", 32'(compressed_count), 32'd7);

    // C.MV, C.ADDI(-32), C.XOR, C.AND
    send(32'h00B0_0533, 1'b0);
    send(32'hFE02_8293, 1'b0);
    wait_word("mv_addi", 32'h1281_852E, 1'b0);
    send(32'h00F4_C4B3, 1'b0);
    send(32'h0087_F7B3, 1'b0);
    wait_word("xor_and", 32'h8FE1_8CBD, 1'b0);
    chk("mix_count", 32'(compressed_count), 32'd11);

    // Boundaries that must pass through uncompressed
    send(32'h0202_8293, 1'b0);
    wait_word("addi_32", 32'h0202_8293, 1'b0);
    send(32'h0010_0013, 1'b0);
    wait_word("addi_x0_1", 32'h0010_0013, 1'b0);
    send(32'h0098_4833, 1'b0);
    wait_word("xor_x16", 32'h0098_4833, 1'b0);
    send(32'h0094_0432, 1'b0);
    wait_word("low_bits_10", 32'h0094_0432, 1'b0);
    send(32'h01F0_0513, 1'b1);
    wait_word("li_31_last", 32'h0001_457D, 1'b1);
    chk("bound_count", 32'(compressed_count), 32'd12);

    // lw x9,8(x8): compressed only with load/store support
    send(32'h0084_2483, 1'b1);
    wait_word("lw", LW_WORD, 1'b1);
    chk("lw_count", 32'(compressed_count), 32'(LW_CNT));

    // Counter saturation
    for (int i = 0; i < 20; i++) send(32'h0094_0433, 1'b0);
    @(posedge clk); #1;
    chk("sat_count", 32'(compressed_count), 32'd15);
    send(32'h0094_0433, 1'b0);
    chk("sat_hold_count", 32'(compressed_count), 32'd15);

    // Reset with a halfword held discards it
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_count", 32'(compressed_count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_idle", 32'(out_valid), 32'd0);
    send(32'h0094_0433, 1'b1);
    wait_word("post_rst", 32'h0001_9426, 1'b1);
    chk("post_rst_count", 32'(compressed_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/compact_instruction_packer.md
Name: compact_instruction_packer

Overview:
Reverse of the compressed-instruction expander. Accepts a stream of 32-bit RV32I instructions. Re-encodes each one as a 16-bit RVC instruction when an exact compressed equivalent exists, and packs the resulting halfwords little-endian into 32-bit words for instruction-memory images. Sits between the program loader/assembler path and the instruction-memory write port; its output, when expanded again, must reproduce the input instructions.

Parameters:
COUNT_WIDTH, 16, width of the saturating compressed-instruction counter

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input instruction valid
in_ready  output  1  packer accepts input this cycle
in_instruction  input  32  uncompressed RV32I instruction
in_last  input  1  final instruction of stream; forces flush
out_valid  output  1  out_word valid
out_ready  input  1  consumer accepts out_word
out_word  output  32  packed word; bits[15:0] = lower address halfword
out_last  output  1  marks final word of stream
compressed_count  output  COUNT_WIDTH  instructions compressed since reset; saturates at all-ones

Behaviour:
- Reset: out_valid=0, out_last=0, out_word=0, hold register empty, state=RUN, compressed_count=0. Reset mid-stream discards the hold halfword and any pending output.
- Input handshake: transfer occurs when in_valid && in_ready. in_ready = (state==RUN) && (!out_valid || out_ready).
- Output handshake: out_word is stable while out_valid && !out_ready.
- Compression is combinational on in_instruction. Exact rules:
  - add rd,rd,rs2 (rd≠0, rs2≠0) -> C.ADD.
  - add rd,x0,rs2 (rd≠0, rs2≠0) -> C.MV.
  - sub/xor/or/and rd,rd,rs2 with rd and rs2 in x8..x15 -> C.SUB/C.XOR/C.OR/C.AND.
  - addi rd,rd,imm (rd≠0, imm≠0, −32≤imm≤31) -> C.ADDI.
  - addi rd,x0,imm (rd≠0, −32≤imm≤31) -> C.LI.
  - addi x0,x0,0 -> C.NOP (0x0001).
  - Everything else passes through as 32 bits. Any input with bits[1:0]≠11 is passed through unmodified as 32 bits.
- Packing on accept, with H = hold halfword:
  - 16-bit result c, hold empty: H=c, no output.
  - 16-bit result c, hold full: out_word={c,H}, hold empty.
  - 32-bit result i, hold empty: out_word=i.
  - 32-bit result i, hold full: out_word={i[15:0],H}, H=i[31:16]. The instruction straddles words.
- Latency: an output word is registered; out_valid rises the cycle after the accepting edge.
- Flush: on an accept with in_last=1:
  - If the hold is empty after packing, the produced word carries out_last=1.
  - If a 16-bit result is held with no word produced, it emits {0x0001,H} with out_last=1.
  - If a word was produced and a halfword remains held, go to state PAD (in_ready=0). When the output slot frees, emit {0x0001,H} with out_last=1, then return to RUN.
- States: RUN and PAD only.
- compressed_count increments by 1 on each accepted instruction that compresses. Pad NOPs are not counted. Holds at 2^COUNT_WIDTH−1.

Optional Feature:
COMPACT_LOADSTORE_EN:
- Defined: additionally compress lw rd,off(rs1) -> C.LW and sw rs2,off(rs1) -> C.SW. Both require rd/rs1/rs2 in x8..x15, off a multiple of 4, and 0≤off≤124. Also lw rd,off(x2) -> C.LWSP (rd≠0, off multiple of 4, 0≤off≤252) and sw rs2,off(x2) -> C.SWSP (off multiple of 4, 0≤off≤252).
- Undefined: loads and stores always pass through as 32 bits.

Decomposition:
- Shared package: RV32I opcode and funct3/funct7 constants, RVC quadrant/funct3 constants, C.NOP value, and the packer state enum. The same constants are used by the expander.
- One sub-module: rvc_compress_encoder. Purely combinational; outputs is_compressible and the 16-bit code. The packer module owns the handshake, hold register, FSM and counter.

Test Plan:
- Two add x8,x8,x9 (0x00940433), out_ready=1 -> one word 0x94269426 one cycle after the 2nd accept; compressed_count=2.
- sub x8,x8,x9 (0x40940433) then li x10,5 (0x00500513, in_last=1) -> word 0x45158C05 with out_last=1.
- add x8,x8,x9 then addi x10,x0,100 (0x06400513, in_last=1):
  - First word 0x05139426 with out_last=0.
  - PAD state with in_ready=0.
  - Second word 0x00010640 with out_last=1.
- Hold out_ready=0 with a word pending -> out_word and out_valid stable and in_ready=0. Raise out_ready -> exactly one transfer, no data loss.
- Preload compressed_count near saturation (COUNT_WIDTH=4, 20 compressible inputs) -> count stops at 15. Reset mid-stream with a held halfword -> no output, count 0.
- With COMPACT_LOADSTORE_EN: lw x9,8(x8) (0x00842483) -> halfword 0x4404. Without the macro -> 32-bit pass-through.
